// File: rtl/ppu_pkg.sv
// Shared PPU constants and types for the OAM line scanner and its sprite list.
// The Y-window test is kept here so the scanner and any future fetcher agree on it.
package ppu_pkg;

  localparam int OAM_ENTRIES      = 40;
  localparam int MAX_LINE_SPRITES = 10;
  localparam int OAM_Y_OFFSET     = 16;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } oam_pos_t;

  typedef struct packed {
    logic [5:0] idx;
    logic [7:0] x;
  } line_sprite_t;

  // 9-bit math so ly + bias and y + height never wrap.
  function automatic logic y_hit(input logic [7:0] ly, input logic tall,
                                 input logic [7:0] y, input logic [8:0] bias);
    logic [8:0] line_pos;
    logic [8:0] top;
    logic [8:0] height;
    line_pos = {1'b0, ly} + bias;
    top      = {1'b0, y};
    height   = tall ? 9'd16 : 9'd8;
    return (line_pos >= top) && (line_pos < top + height);
  endfunction

endpackage

// File: rtl/oam_line_scanner_if.sv
// Bundle between the PPU controller / OAM RAM (master) and the line scanner (slave).
// Carries the scan handshake, the OAM read bus and the selected-list read port.
interface oam_line_scanner_if;
  import ppu_pkg::*;

  logic        start;
  logic [7:0]  ly;
  logic        tall;
  logic [6:0]  oam_addr;
  logic [15:0] oam_data;
  logic        busy;
  logic        done;
  logic [3:0]  count;
  logic [3:0]  rd_slot;
  logic [7:0]  rd_x;
  logic [5:0]  rd_oam_idx;

  modport master (
    output start, ly, tall, oam_data, rd_slot,
    input  oam_addr, busy, done, count, rd_x, rd_oam_idx
  );

  modport slave (
    input  start, ly, tall, oam_data, rd_slot,
    output oam_addr, busy, done, count, rd_x, rd_oam_idx
  );

endinterface

// File: rtl/oam_line_scanner_list.sv
// sprite_line_list: the per-line selected-sprite register file.
// Clear resets only the count; entries stay stale until overwritten.
module sprite_line_list
  import ppu_pkg::*;
#(
  parameter int MAX_SPRITES = MAX_LINE_SPRITES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         append,
  input  line_sprite_t append_data,
  input  logic [3:0]   rd_slot,
  output logic [3:0]   count,
  output line_sprite_t rd_data
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_SPRITES);

  line_sprite_t list [MAX_SPRITES];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < MAX_SPRITES; i++) list[i] <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (append && (count < MAX_CNT)) begin
      list[count] <= append_data;
      count       <= count + 4'd1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rd_data = '0;
    if (rd_slot < MAX_CNT) rd_data = list[rd_slot];
  end

endmodule

// File: rtl/ram_80words_16bit.sv
// Sprite attribute RAM: 80 x 16 bits, single address port, registered read (1 clock).
// Addresses past the last word read as zero and ignore writes.
module ram_80words_16bit (
  input  logic        clk,
  input  logic        we,
  input  logic [6:0]  addr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out
);

  localparam logic [6:0] DEPTH = 7'd80;

  logic [15:0] mem [80];

  // NOTE: RAM arrays get no reset so they map onto block/SRAM macros; contents are
  // defined by the loader before any scan reads them.
  always_ff @(posedge clk) begin
    if (addr < DEPTH) begin
      if (we) mem[addr] <= d_in;
      d_out <= mem[addr];
    end else begin
      d_out <= '0;
    end
  end

endmodule

// File: rtl/oam_line_scanner.sv
// Walks all OAM entries once per start pulse and keeps the first MAX_SPRITES whose
// vertical span covers the latched line; the list is held for the pixel fetcher.
module oam_line_scanner
  import ppu_pkg::*;
#(
  parameter int ENTRIES     = OAM_ENTRIES,
  parameter int MAX_SPRITES = MAX_LINE_SPRITES,
  parameter int Y_OFFSET    = OAM_Y_OFFSET
) (
  input  logic                 clk,
  input  logic                 rst_n,
  oam_line_scanner_if.slave    bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;
  localparam logic [6:0] C_LAST  = 7'(2 * ENTRIES - 1);
  localparam logic [8:0] BIAS    = 9'(Y_OFFSET);

  logic [0:0]   state;
  logic [6:0]   c;
  logic [7:0]   ly_q;
  logic         tall_q;
  logic         done_q;
  oam_pos_t     pos;
  logic         hit;
  logic         append;
  line_sprite_t new_entry;
  line_sprite_t rd_data;

  assign pos = bus.oam_data;

  // Entry address is held for both clocks of an entry; data arrives on the odd one.
  assign bus.oam_addr = {c[6:1], 1'b0};

  assign hit       = (state == ST_SCAN) && c[0] && y_hit(ly_q, tall_q, pos.y, BIAS);
  assign append    = hit && !bus.start;
  assign new_entry = '{idx: c[6:1], x: pos.x};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      c      <= '0;
      ly_q   <= '0;
      tall_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        // A start always wins, including on the final compare: the old scan is dropped.
        state  <= ST_SCAN;
        c      <= '0;
        ly_q   <= bus.ly;
        tall_q <= bus.tall;
      end else if (state == ST_SCAN) begin
        if (c == C_LAST) begin
          state  <= ST_IDLE;
          c      <= '0;
          done_q <= 1'b1;
        end else begin
          c <= c + 7'd1;
        end
      end
    end
  end

  sprite_line_list #(
    .MAX_SPRITES (MAX_SPRITES)
  ) u_list (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (bus.start),
    .append      (append),
    .append_data (new_entry),
    .rd_slot     (bus.rd_slot),
    .count       (bus.count),
    .rd_data     (rd_data)
  );

  assign bus.busy       = (state == ST_SCAN);
  assign bus.done       = done_q;
  assign bus.rd_x       = rd_data.x;
  assign bus.rd_oam_idx = rd_data.idx;

endmodule
